mem_arbiter_rr: RTL and testbench
=================================

// Module: mem_arbiter_rr
// PURPOSE
//  Two-requester arbiter and sequencer for the single-port synchronous `memory` block.
//  Sits between two masters (e.g. fill engine and readback checker) and the memory.
//  Grants one access per cycle with a valid/ready handshake and bounded-burst round-robin fairness.
//  Routes each read response back to the requester that issued it.
// PARAMETERS
//  WIDTH      32   data width; matches memory WIDTH
//  DEPTH      256  memory words; informational, DEPTH = 2**ADDR
//  ADDR       8    address width; matches memory ADDR
//  MAX_BURST  4    max back-to-back grants to one requester while the other waits (>=1; 1 = pure round-robin)
// PORTS
//  clk          in   1      clock; all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has a command
//  req0_wr      in   1      1 = write, 0 = read
//  req0_addr    in   ADDR   command address
//  req0_wdata   in   WIDTH  write data; ignored for reads
//  req0_ready   out  1      command accepted this cycle (combinational from valids + state)
//  rsp0_valid   out  1      read data for requester 0 is valid this cycle
//  rsp0_rdata   out  WIDTH  read data
//  req1_* / rsp1_*  --   --  same set of ports for requester 1
//  mem_addr     out  ADDR   to memory addr
//  mem_wdata    out  WIDTH  to memory wdata
//  mem_wrbar    out  1      to memory wrbar: 1 = write, 0 = read (memory convention)
//  mem_rdata    in   WIDTH  from memory rdata; valid the cycle after a read is presented
// BEHAVIOUR
//  Handshake: a command transfers on any posedge where reqN_valid && reqN_ready.
//   - At most one ready per cycle.
//   - ready may be high only when the matching valid is high.
//   - A requester holds valid/wr/addr/wdata stable until accepted.
//  FSM state {IDLE, OWN0, OWN1} plus cnt (1..MAX_BURST) = consecutive grants to the current owner.
//   - IDLE: no grant in the previous cycle.
//   - Only one valid: grant it. Next state OWNn; cnt=1 if the owner changed or the state was IDLE, else cnt+1 saturating at MAX_BURST.
//   - Both valid in OWNn with cnt<MAX_BURST: grant n (cnt+1).
//   - Both valid in OWNn with cnt==MAX_BURST: grant the other (cnt=1).
//   - Both valid in IDLE: grant the requester not granted most recently (last_gnt); last_gnt resets to 1, so req0 wins first.
//   - No valid: next state IDLE; cnt is a don't-care; last_gnt is kept.
//  Issue (accept at edge T):
//   - mem_addr/mem_wdata/mem_wrbar are registered and present the command throughout cycle T+1.
//   - The memory acts at edge T+1.
//  Idle: mem_wrbar=0 (read, harmless); mem_addr and mem_wdata hold their last values. The arbiter never issues a spurious write.
//  Response:
//   - A 2-stage tag pipe (valid, id, is_read) follows each command.
//   - For a read accepted at edge T, rspN_valid=1 with rspN_rdata=mem_rdata during cycle T+2, for exactly one cycle.
//   - Writes produce no response. rsp of the non-target requester stays 0.
//  Throughput: one access per cycle, no bubbles on owner switch.
//   - Read-after-write to the same address, issued back-to-back, returns the new data, since the memory completes the write at the earlier edge.
//  Reset: at any edge with rst=1, outputs go to 0 in the following cycle:
//   - ready0/1 = 0 (combinational, forced low while rst=1)
//   - rsp0/1_valid = 0; rsp0/1_rdata = 0
//   - mem_wrbar = 0; mem_addr = 0; mem_wdata = 0
//   - state = IDLE; last_gnt = 1; tag pipe cleared
//   - In-flight reads are dropped, not replayed. Commands presented during rst are not accepted.
//  Width rules: cnt is $clog2(MAX_BURST+1) bits, saturating. Address passes through unmodified (no wrap logic; ADDR-bit address covers DEPTH).
// TESTING
//  1. rst=1 for 2 cycles, both valid -> no ready; mem_wrbar=0; rsp*_valid=0 throughout; req0 granted first cycle after rst drops.
//  2. req0 only: write addr 0..255 with data 32'hA5000000+i, then read 0..255 -> one accept/cycle; rsp0_rdata = written value exactly 2 cycles after each accept.
//  3. Both valid continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... ; no cycle without a grant.
//  4. req1 writes 0xDEADBEEF to addr 8 (accepted edge T), req0 reads addr 8 (accepted edge T+1) -> rsp0_valid at T+3 with 0xDEADBEEF; rsp1_valid stays 0.
//  5. Owner drops valid after 2 grants while the other requests -> immediate switch, cnt restarts at 1; owner returning next cycle waits per fairness.
//  6. Assert rst one cycle after a read is accepted -> no rsp_valid for that read; mem_wrbar=0; arbitration restarts with req0 priority.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: two-requester front end for the single-port synchronous memory.
// Grants one command per cycle with bounded-burst round-robin fairness, registers the
// granted command onto the memory port, and steers each read response back to the
// requester that issued it via a two-stage tag pipe.
module mem_arbiter_rr #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR      = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_wr,
  input  logic [ADDR-1:0]  req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_rdata,
  input  logic             req1_valid,
  input  logic             req1_wr,
  input  logic [ADDR-1:0]  req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_rdata,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wrbar,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // A memory deeper than the address can reach, or a zero burst limit, is a wiring error.
  if (DEPTH > (1 << ADDR) || MAX_BURST < 1) begin : g_bad_params
    $error("mem_arbiter_rr: DEPTH must fit in ADDR bits and MAX_BURST must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic          gnt0, gnt1;

  logic          s1_valid, s1_id, s1_read;
  logic          s2_valid, s2_id, s2_read;

  // Pick the winner for this cycle and work out the owner/burst bookkeeping that follows.
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_nxt    = IDLE;
    cnt_nxt      = cnt;
    last_gnt_nxt = last_gnt;
    if (!rst) begin
      if (req0_valid && !req1_valid) begin
        gnt0 = 1'b1;
      end else if (!req0_valid && req1_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        case (state)
          OWN0:    if (cnt < CNT_MAX) gnt0 = 1'b1; else gnt1 = 1'b1;
          OWN1:    if (cnt < CNT_MAX) gnt1 = 1'b1; else gnt0 = 1'b1;
          default: if (last_gnt) gnt0 = 1'b1; else gnt1 = 1'b1;
        endcase
      end
    end
    if (gnt0) begin
      state_nxt    = OWN0;
      last_gnt_nxt = 1'b0;
      if (state == OWN0) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      else               cnt_nxt = CNT_ONE;
    end else if (gnt1) begin
      state_nxt    = OWN1;
      last_gnt_nxt = 1'b1;
      if (state == OWN1) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      else               cnt_nxt = CNT_ONE;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Arbitration state register; last_gnt starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Register the granted command onto the memory port; idle cycles are harmless reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wrbar <= 1'b0;
    end else if (gnt0) begin
      mem_addr  <= req0_addr;
      mem_wdata <= req0_wdata;
      mem_wrbar <= req0_wr;
    end else if (gnt1) begin
      mem_addr  <= req1_addr;
      mem_wdata <= req1_wdata;
      mem_wrbar <= req1_wr;
    end else begin
      mem_wrbar <= 1'b0;
    end
  end

  // Tag pipe tracks each command until its read data appears, two cycles after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_read  <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_read  <= 1'b0;
    end else begin
      s1_valid <= gnt0 | gnt1;
      s1_id    <= gnt1;
      s1_read  <= (gnt0 & ~req0_wr) | (gnt1 & ~req1_wr);
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_read  <= s1_read;
    end
  end

  assign rsp0_valid = s2_valid & s2_read & ~s2_id;
  assign rsp1_valid = s2_valid & s2_read &  s2_id;
  assign rsp0_rdata = rsp0_valid ? mem_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed stimulus for mem_arbiter_rr with a behavioural memory,
// a shadow copy of expected memory contents and a response scoreboard.
module tb_mem_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_wr = 1'b0;
  logic [7:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ready, rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid = 1'b0, req1_wr = 1'b0;
  logic [7:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ready, rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wrbar;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mem[256];
  logic [31:0] sh[256];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic        last_acc0, last_acc1;

  mem_arbiter_rr #(.WIDTH(32), .DEPTH(256), .ADDR(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrbar(mem_wrbar), .mem_rdata(mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to time responses.
  always @(posedge clk) cyc++;

  // Single-port synchronous memory: write when wrbar=1, otherwise registered read.
  always @(posedge clk) begin
    if (mem_wrbar) mem[mem_addr] <= mem_wdata;
    else           mem_rdata     <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drive one cycle of commands, check the grant, book-keep accepts, then check the memory port.
  task automatic applyStimulus(input logic r,
                               input logic v0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                               input logic v1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                               input int exp_gnt);
    logic acc0, acc1;
    rst = r;
    req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
    checkOutput("ready0", {31'b0, req0_ready}, {31'b0, exp_gnt == 0});
    checkOutput("ready1", {31'b0, req1_ready}, {31'b0, exp_gnt == 1});
    acc0 = v0 && req0_ready;
    acc1 = v1 && req1_ready;
    if (acc0) begin
      if (w0) sh[a0] = d0;
      else    sb.push_back('{1'b0, sh[a0], cyc + 2});
    end
    if (acc1) begin
      if (w1) sh[a1] = d1;
      else    sb.push_back('{1'b1, sh[a1], cyc + 2});
    end
    last_acc0 = acc0;
    last_acc1 = acc1;
    @(posedge clk);
    #1;
    if (r) begin
      checkOutput("rst_mem_wrbar", {31'b0, mem_wrbar}, 32'd0);
      checkOutput("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      while (sb.size() > 0 && sb[sb.size()-1].due >= cyc) void'(sb.pop_back());
    end else begin
      checkOutput("mem_wrbar", {31'b0, mem_wrbar}, {31'b0, (acc0 && w0) || (acc1 && w1)});
      if (acc0) checkOutput("mem_addr0", {24'b0, mem_addr}, {24'b0, a0});
      if (acc1) checkOutput("mem_addr1", {24'b0, mem_addr}, {24'b0, a1});
      if (acc0 && w0) checkOutput("mem_wdata0", mem_wdata, d0);
      if (acc1 && w1) checkOutput("mem_wdata1", mem_wdata, d1);
    end
  endtask

  // Response monitor: every response must match the oldest outstanding read, on time.
  always @(negedge clk) begin
    rsp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checkOutput("rsp_missing", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    checkOutput("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
    if (!rsp0_valid) checkOutput("rsp0_rdata_idle", rsp0_rdata, 32'd0);
    if (!rsp1_valid) checkOutput("rsp1_rdata_idle", rsp1_rdata, 32'd0);
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", {31'b0, rsp1_valid}, {31'b0, e.id});
        checkOutput("rsp_data", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.data);
        checkOutput("rsp_time", cyc, e.due);
      end
    end
  end

  initial begin
    int n0, n1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      sh[i]  = '0;
    end

    // Reset with both requesters asking: nothing may be accepted.
    $display("[TB] reset with both valid");
    applyStimulus(1, 1, 0, 8'd1, 32'd0, 1, 0, 8'd2, 32'd0, -1);
    applyStimulus(1, 1, 0, 8'd1, 32'd0, 1, 0, 8'd2, 32'd0, -1);

    // Continuous contention: bursts of four, starting with requester 0.
    $display("[TB] bounded-burst round robin");
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0, 8'(n0), 32'd0, 1, 0, 8'(128 + n1), 32'd0, (k / 4) % 2);
      if (last_acc0) n0++;
      if (last_acc1) n1++;
    end

    // Requester 0 alone fills and reads back the whole memory.
    $display("[TB] full write/read sweep by requester 0");
    for (int i = 0; i < 256; i++)
      applyStimulus(0, 1, 1, 8'(i), 32'hA500_0000 + 32'(i), 0, 0, 8'd0, 32'd0, 0);
    for (int i = 0; i < 256; i++)
      applyStimulus(0, 1, 0, 8'(i), 32'd0, 0, 0, 8'd0, 32'd0, 0);

    // Owner drops after two grants; the other takes over with a fresh burst.
    $display("[TB] owner drop and fairness");
    applyStimulus(0, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, -1);
    applyStimulus(0, 1, 1, 8'd20, 32'h1111_0000, 0, 0, 8'd0, 32'd0, 0);
    applyStimulus(0, 1, 1, 8'd21, 32'h1111_0001, 0, 0, 8'd0, 32'd0, 0);
    applyStimulus(0, 0, 0, 8'd0, 32'd0, 1, 0, 8'd20, 32'd0, 1);
    applyStimulus(0, 1, 0, 8'd21, 32'd0, 1, 0, 8'd21, 32'd0, 1);
    applyStimulus(0, 1, 0, 8'd21, 32'd0, 1, 1, 8'd22, 32'h2222_0002, 1);
    applyStimulus(0, 1, 0, 8'd21, 32'd0, 1, 0, 8'd22, 32'd0, 1);
    applyStimulus(0, 1, 0, 8'd21, 32'd0, 1, 0, 8'd23, 32'd0, 0);
    applyStimulus(0, 0, 0, 8'd0, 32'd0, 1, 0, 8'd23, 32'd0, 1);

    // Cross-requester read-after-write, issued back to back.
    $display("[TB] read-after-write across requesters");
    applyStimulus(0, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, -1);
    applyStimulus(0, 0, 0, 8'd0, 32'd0, 1, 1, 8'd8, 32'hDEAD_BEEF, 1);
    applyStimulus(0, 1, 0, 8'd8, 32'd0, 0, 0, 8'd0, 32'd0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, -1);

    // Reset one cycle after a read: the read is dropped and requester 0 regains priority.
    $display("[TB] reset during an in-flight read");
    applyStimulus(0, 1, 0, 8'd3, 32'd0, 0, 0, 8'd0, 32'd0, 0);
    applyStimulus(1, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, -1);
    applyStimulus(0, 1, 0, 8'd4, 32'd0, 1, 0, 8'd5, 32'd0, 0);
    applyStimulus(0, 0, 0, 8'd0, 32'd0, 1, 0, 8'd5, 32'd0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 8'd0, 32'd0, 0, 0, 8'd0, 32'd0, -1);

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
